// File: rtl/wb_arbiter.sv
// Writeback arbiter: two 2-entry result FIFOs (ALU, MEM) merged round-robin into
// one registered register-file write port, at most one writeback per cycle.
module wb_arbiter #(
    parameter int W_OPR = 32,
    parameter int W_RA  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid_i,
    input  logic [W_RA-1:0]  alu_addr_i,
    input  logic [W_OPR-1:0] alu_data_i,
    output logic             alu_ready_o,
    input  logic             mem_valid_i,
    input  logic [W_RA-1:0]  mem_addr_i,
    input  logic [W_OPR-1:0] mem_data_i,
    output logic             mem_ready_o,
    output logic             wb_en_o,
    output logic [W_RA-1:0]  wb_addr_o,
    output logic [W_OPR-1:0] wb_data_o
);

    logic [W_RA-1:0]  alu_addr_q [2];
    logic [W_OPR-1:0] alu_data_q [2];
    logic [1:0]       alu_cnt;
    logic             alu_wp;
    logic             alu_rp;

    logic [W_RA-1:0]  mem_addr_q [2];
    logic [W_OPR-1:0] mem_data_q [2];
    logic [1:0]       mem_cnt;
    logic             mem_wp;
    logic             mem_rp;

    logic             pref;
    logic             alu_push;
    logic             mem_push;
    logic             alu_nempty;
    logic             mem_nempty;
    logic             grant_alu;
    logic             grant_mem;

    assign alu_ready_o = (alu_cnt != 2'd2);
    assign mem_ready_o = (mem_cnt != 2'd2);
    assign alu_push    = alu_valid_i && alu_ready_o;
    assign mem_push    = mem_valid_i && mem_ready_o;
    assign alu_nempty  = (alu_cnt != 2'd0);
    assign mem_nempty  = (mem_cnt != 2'd0);

    // Grants look only at registered counts, so a same-edge push is never bypassed.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (alu_nempty && (!mem_nempty || !pref)) begin
            grant_alu = 1'b1;
        end else if (mem_nempty) begin
            grant_mem = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && alu_push) begin
            alu_addr_q[alu_wp] <= alu_addr_i;
            alu_data_q[alu_wp] <= alu_data_i;
        end
        if (reset && mem_push) begin
            mem_addr_q[mem_wp] <= mem_addr_i;
            mem_data_q[mem_wp] <= mem_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_cnt   <= 2'd0;
            alu_wp    <= 1'b0;
            alu_rp    <= 1'b0;
            mem_cnt   <= 2'd0;
            mem_wp    <= 1'b0;
            mem_rp    <= 1'b0;
            pref      <= 1'b0;
            wb_en_o   <= 1'b0;
            wb_addr_o <= '0;
            wb_data_o <= '0;
        end else begin
            if (alu_push)  alu_wp <= ~alu_wp;
            if (grant_alu) alu_rp <= ~alu_rp;
            if (mem_push)  mem_wp <= ~mem_wp;
            if (grant_mem) mem_rp <= ~mem_rp;

            case ({alu_push, grant_alu})
                2'b10:   alu_cnt <= alu_cnt + 2'd1;
                2'b01:   alu_cnt <= alu_cnt - 2'd1;
                default: alu_cnt <= alu_cnt;
            endcase
            case ({mem_push, grant_mem})
                2'b10:   mem_cnt <= mem_cnt + 2'd1;
                2'b01:   mem_cnt <= mem_cnt - 2'd1;
                default: mem_cnt <= mem_cnt;
            endcase

            wb_en_o <= grant_alu || grant_mem;
            // Address/data hold their last value on idle cycles.
            if (grant_alu) begin
                wb_addr_o <= alu_addr_q[alu_rp];
                wb_data_o <= alu_data_q[alu_rp];
                pref      <= 1'b1;
            end else if (grant_mem) begin
                wb_addr_o <= mem_addr_q[mem_rp];
                wb_data_o <= mem_data_q[mem_rp];
                pref      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed pushes queue hand-ordered expected
// writebacks; a negedge monitor pops and compares every wb_en_o pulse.
module tb_wb_arbiter;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alu_valid_i = 1'b0;
    logic [4:0]  alu_addr_i = '0;
    logic [31:0] alu_data_i = '0;
    logic        alu_ready_o;
    logic        mem_valid_i = 1'b0;
    logic [4:0]  mem_addr_i = '0;
    logic [31:0] mem_data_i = '0;
    logic        mem_ready_o;
    logic        wb_en_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int expected_pulses = 0;
    wb_t exp_q[$];

    wb_arbiter #(.W_OPR(32), .W_RA(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid_i(alu_valid_i),
        .alu_addr_i (alu_addr_i),
        .alu_data_i (alu_data_i),
        .alu_ready_o(alu_ready_o),
        .mem_valid_i(mem_valid_i),
        .mem_addr_i (mem_addr_i),
        .mem_data_i (mem_data_i),
        .mem_ready_o(mem_ready_o),
        .wb_en_o    (wb_en_o),
        .wb_addr_o  (wb_addr_o),
        .wb_data_o  (wb_data_o)
    );

    always #5 clk = ~clk;

    // Monitor: every writeback pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (wb_en_o === 1'b1) begin
            wb_t exp;
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL wb_unexpected: got addr=%0d data=%h, expected no writeback",
                         wb_addr_o, wb_data_o);
            end else begin
                exp = exp_q.pop_front();
                if (wb_addr_o !== exp.addr || wb_data_o !== exp.data) begin
                    errors++;
                    $display("[TB] FAIL wb_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                             wb_addr_o, wb_data_o, exp.addr, exp.data);
                end
            end
        end
    end

    task automatic expectWb(input logic [4:0] addr, input logic [31:0] data);
        wb_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
        expected_pulses++;
    endtask

    // Drives one cycle of inputs across a rising edge, returning at the next negedge.
    task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                 input logic mv, input logic [4:0] ma, input logic [31:0] md);
        alu_valid_i = av;
        alu_addr_i  = aa;
        alu_data_i  = ad;
        mem_valid_i = mv;
        mem_addr_i  = ma;
        mem_data_i  = md;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    initial begin
        // Reset with both producers offering data: nothing may be accepted.
        reset = 1'b0;
        applyStimulus(1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd6, 32'hBEEF);
        applyStimulus(1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd6, 32'hBEEF);
        checkOutput("reset_wb_en", {31'b0, wb_en_o}, 32'd0);
        checkOutput("reset_wb_addr", {27'b0, wb_addr_o}, 32'd0);
        checkOutput("reset_wb_data", wb_data_o, 32'd0);
        checkOutput("reset_alu_ready", {31'b0, alu_ready_o}, 32'd1);
        checkOutput("reset_mem_ready", {31'b0, mem_ready_o}, 32'd1);
        reset = 1'b1;
        repeat (3) idle();

        // Single ALU result: visible after the second edge, one cycle only.
        expectWb(5'd3, 32'h0000_00AA);
        applyStimulus(1'b1, 5'd3, 32'h0000_00AA, 1'b0, 5'd0, 32'h0);
        checkOutput("single_no_bypass", {31'b0, wb_en_o}, 32'd0);
        idle();
        checkOutput("single_wb_en", {31'b0, wb_en_o}, 32'd1);
        idle();
        checkOutput("single_wb_en_drop", {31'b0, wb_en_o}, 32'd0);

        // Contention right after reset: ALU first, then MEM, pref returns to ALU.
        reset = 1'b0;
        idle();
        reset = 1'b1;
        expectWb(5'd1, 32'h11);
        expectWb(5'd2, 32'h22);
        applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        idle();
        checkOutput("contend_first", {31'b0, wb_en_o}, 32'd1);
        idle();
        checkOutput("contend_second", {31'b0, wb_en_o}, 32'd1);
        expectWb(5'd8, 32'h88);
        expectWb(5'd9, 32'h99);
        applyStimulus(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99);
        repeat (3) idle();

        // Fill MEM while ALU stays busy; M3 is refused once, then accepted.
        expectWb(5'd10, 32'hA1);
        expectWb(5'd20, 32'hB1);
        expectWb(5'd11, 32'hA2);
        expectWb(5'd21, 32'hB2);
        expectWb(5'd12, 32'hA3);
        expectWb(5'd22, 32'hB3);
        applyStimulus(1'b1, 5'd10, 32'hA1, 1'b1, 5'd20, 32'hB1);
        checkOutput("fill_ready_cnt1", {31'b0, mem_ready_o}, 32'd1);
        applyStimulus(1'b1, 5'd11, 32'hA2, 1'b1, 5'd21, 32'hB2);
        checkOutput("fill_ready_full", {31'b0, mem_ready_o}, 32'd0);
        applyStimulus(1'b1, 5'd12, 32'hA3, 1'b1, 5'd22, 32'hB3);
        checkOutput("fill_ready_after_pop", {31'b0, mem_ready_o}, 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd22, 32'hB3);
        checkOutput("fill_ready_full_again", {31'b0, mem_ready_o}, 32'd0);
        repeat (5) idle();

        // MEM alone streams: push and pop each cycle keep the FIFO at one entry.
        for (int i = 0; i < 5; i++) begin
            expectWb(5'(24 + i), 32'hC0 + 32'(i));
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(24 + i), 32'hC0 + 32'(i));
            checkOutput("stream_ready", {31'b0, mem_ready_o}, 32'd1);
            if (i > 0) checkOutput("stream_wb_en", {31'b0, wb_en_o}, 32'd1);
        end
        idle();
        checkOutput("stream_last_wb_en", {31'b0, wb_en_o}, 32'd1);
        idle();

        // Reset with entries queued in both FIFOs: only A1 escapes beforehand.
        expectWb(5'd13, 32'hD1);
        applyStimulus(1'b1, 5'd13, 32'hD1, 1'b1, 5'd23, 32'hE1);
        applyStimulus(1'b1, 5'd14, 32'hD2, 1'b1, 5'd27, 32'hE2);
        reset = 1'b0;
        applyStimulus(1'b1, 5'd15, 32'hD3, 1'b1, 5'd28, 32'hE3);
        checkOutput("midreset_wb_en", {31'b0, wb_en_o}, 32'd0);
        reset = 1'b1;
        repeat (3) idle();
        checkOutput("midreset_quiet", {31'b0, wb_en_o}, 32'd0);
        checkOutput("midreset_alu_ready", {31'b0, alu_ready_o}, 32'd1);
        checkOutput("midreset_mem_ready", {31'b0, mem_ready_o}, 32'd1);
        expectWb(5'd0, 32'h77);
        applyStimulus(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'h0);
        idle();
        checkOutput("fresh_wb_en", {31'b0, wb_en_o}, 32'd1);

        // Bounded drain before the final accounting.
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) idle();
        idle();
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("pulse_count", 32'(pulses), 32'(expected_pulses));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback stage between the execution units and the general-register cells. Accepts results from two producers, ALU and MEM, each through a valid/ready handshake into its own 2-entry FIFO. Arbitrates round-robin and issues at most one registered writeback per cycle (enable, register address, data) to the register file. The writeback enable is the signal that loads a cell and clears its write reservation.

## Interface
- W_OPR, 32: operand/data width
- W_RA, 5: register address width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset, sampled on rising edge of clk
- alu_valid_i  in  1  ALU result valid
- alu_addr_i  in  W_RA  ALU destination register
- alu_data_i  in  W_OPR  ALU result
- alu_ready_o  out  1  ALU FIFO can accept
- mem_valid_i  in  1  MEM result valid
- mem_addr_i  in  W_RA  MEM destination register
- mem_data_i  in  W_OPR  MEM (load) result
- mem_ready_o  out  1  MEM FIFO can accept
- wb_en_o  out  1  writeback strobe to register file, one cycle per result
- wb_addr_o  out  W_RA  writeback destination register
- wb_data_o  out  W_OPR  writeback data

## Operation
- Per-source FIFO: 2 entries of {addr, data}, with a 2-bit count and 1-bit read/write pointers that wrap modulo 2.
- Push: on a clock edge where valid_i and ready_o are both high, the entry is written at the write pointer.
- ready_o = (count != 2). It is a function of count only; a same-cycle pop does not raise ready_o when the FIFO is full.
- Pop: a FIFO that is non-empty and granted is popped at the edge. Its head goes into the output registers.
- Count update: push and pop in the same cycle leave count unchanged. Push alone increments; pop alone decrements.
- Arbitration state is a 1-bit pref register: 0 means ALU preferred, 1 means MEM preferred.
  - Only ALU non-empty: grant ALU.
  - Only MEM non-empty: grant MEM.
  - Both non-empty: grant the source named by pref.
  - After any grant, pref is set to the other source, i.e. pref <= (granted == ALU).
  - No grant: pref holds.
- Output register loading:
  - Grant: wb_en_o <= 1, and wb_addr_o/wb_data_o <= head of the granted FIFO.
  - No grant: wb_en_o <= 0, and wb_addr_o/wb_data_o hold their last value.
- Ordering: FIFO order is preserved within a source. Ordering between sources is arbitration order.
- Address 0 is handled like any other address.
- The block applies no backpressure from the register file; it always accepts writebacks.

## Timing
- Reset (reset low at an edge) forces:
  - FIFO counts and pointers to 0
  - pref to 0
  - wb_en_o to 0
  - wb_addr_o to 0
  - wb_data_o to 0
- After reset, alu_ready_o and mem_ready_o are 1.
- Reset mid-operation discards all queued entries. It overrides any push or pop sampled at the same edge.
- Latency: a result accepted at edge k can be popped at edge k+1 at the earliest. wb_en_o is then high for the cycle after edge k+1.
- A FIFO does not bypass to the output. An entry pushed at edge k is not eligible for grant at edge k.
- Throughput: one writeback per cycle in total. Under continuous contention the sources alternate 1:1.
- Empty-FIFO pop cannot occur, because grant requires non-empty.
- Full FIFO: ready_o stays low until a pop reduces count to 1. It rises in the cycle after that pop.

## Test plan
- Reset check: assert reset low for 2 edges while both valids are high with data. Require wb_en_o=0, wb_addr_o=0, wb_data_o=0, both ready=1, and no entry accepted.
- Single ALU result: push addr=3, data=0x0000_00AA at edge k. Require wb_en_o=1, wb_addr_o=3, wb_data_o=0xAA in the cycle after edge k+1. Require wb_en_o=0 in the following cycle.
- Contention: push ALU(1,0x11) and MEM(2,0x22) at the same edge, right after reset. Require the writebacks ALU(1,0x11) then MEM(2,0x22) on consecutive cycles, and pref back at 0.
- Fill/backpressure: push 3 MEM results on consecutive edges while ALU is also continuously non-empty. Require mem_ready_o=0 after 2 unpopped entries, the third held until ready=1, and all three written back in order with no loss or duplication.
- Same-cycle push+pop at count=1: MEM alone streams one result per cycle. Require count to stay at 1, ready to stay at 1, and one wb_en_o pulse per cycle with data matching the input sequence.
- Reset mid-stream: with both FIFOs holding 2 entries, assert reset. Require no further wb_en_o pulses from the old entries, and a subsequent fresh push written back normally.
